// File: rtl/sqrt_iter.sv
// Multi-cycle restoring integer square root, one root bit per clock.
// Returns floor or round-to-nearest root plus the floor remainder.
module sqrt_iter #(
  parameter int WIDTH = 16,
  parameter int RW    = WIDTH / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             round_en,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    root,
  output logic [RW:0]      remainder
);

  if ((WIDTH % 2) != 0 || WIDTH < 4 || RW != WIDTH / 2) begin : g_bad_width
    $error("sqrt_iter: WIDTH must be even and >= 4, RW must be WIDTH/2");
  end

  localparam int CW = $clog2(RW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  opnd;
  logic [RW-1:0]     proot;
  logic [RW-1:0]     prem;
  logic [CW-1:0]     cnt;
  logic              rnd;

  logic              load;
  logic              last;
  logic              fit;
  logic [RW+1:0]     shifted;
  logic [RW+1:0]     trial;
  logic [RW+1:0]     rem_nxt;
  logic [RW-1:0]     root_nxt;
  logic [RW-1:0]     root_fin;

  assign load = start && (state != CALC);
  assign last = (state == CALC) && (cnt == CW'(RW - 1));
  assign busy = (state == CALC);
  assign done = (state == DONE);

  // Partial remainder stays below 2^RW until the last step, so RW bits suffice.
  always_comb begin
    shifted  = {prem, opnd[WIDTH-1 -: 2]};
    trial    = {proot, 2'b01};
    fit      = (shifted >= trial);
    rem_nxt  = fit ? (shifted - trial) : shifted;
    root_nxt = {proot[RW-2:0], fit};
    root_fin = root_nxt;
    if (rnd && (rem_nxt > {2'b00, root_nxt}) && !(&root_nxt))
      root_fin = root_nxt + RW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opnd      <= '0;
      proot     <= '0;
      prem      <= '0;
      cnt       <= '0;
      rnd       <= 1'b0;
      root      <= '0;
      remainder <= '0;
    end else if (load) begin
      opnd  <= data_in;
      rnd   <= round_en;
      proot <= '0;
      prem  <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      opnd  <= {opnd[WIDTH-3:0], 2'b00};
      proot <= root_nxt;
      prem  <= rem_nxt[RW-1:0];
      cnt   <= cnt + CW'(1);
      if (last) begin
        root      <= root_fin;
        remainder <= rem_nxt[RW:0];
      end
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter: random and directed operands against
// an arithmetic reference, with cycle-accurate busy/done expectations.
module tb_sqrt_iter;

  localparam int W  = 16;
  localparam int RW = W / 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  data_in;
  logic          round_en;
  logic          busy;
  logic          done;
  logic [RW-1:0] root;
  logic [RW:0]   remainder;

  sqrt_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .round_en  (round_en),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int m;
    int p;
  } exp_t;

  exp_t q[$];
  int   ncyc = 0;
  int   next_ok = 0;
  int   tests = 0;
  int   fails = 0;
  int   held_r = 0;
  int   held_m = 0;

  always @(posedge clk) ncyc++;

  task automatic check(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, ncyc);
    end
  endtask

  function automatic void ref_sqrt(input int d, input bit rb,
                                   output int r, output int m);
    int f;
    f = 0;
    while ((f + 1) * (f + 1) <= d) f++;
    m = d - f * f;
    r = (rb && m > f && f < (1 << RW) - 1) ? f + 1 : f;
  endfunction

  // Monitor: busy/done timing every cycle, values on done, hold otherwise.
  always @(negedge clk) begin
    bit eb;
    bit ed;
    exp_t e;
    if (!reset) begin
      eb = 1'b0;
      foreach (q[i])
        if (ncyc >= q[i].p && ncyc < q[i].p + RW) eb = 1'b1;
      ed = (q.size() > 0) && (ncyc == q[0].p + RW);
      check("busy", int'(busy), int'(eb));
      check("done", int'(done), int'(ed));
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          held_r = e.r;
          held_m = e.m;
        end
      end
      check("root", int'(root), held_r);
      check("remainder", int'(remainder), held_m);
    end
  end

  task automatic issue(input logic [W-1:0] d, input bit rb);
    int r;
    int m;
    int p;
    @(negedge clk); #1;
    start    = 1'b1;
    data_in  = d;
    round_en = rb;
    p = ncyc + 1;
    if (p >= next_ok) begin
      ref_sqrt(int'(d), rb, r, m);
      q.push_back('{r: r, m: m, p: p});
      next_ok = p + RW + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      start    = 1'b0;
      data_in  = W'($urandom);
      round_en = 1'($urandom);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = '0;
    round_en = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_root", int'(root), 0);
    check("rst_rem", int'(remainder), 0);
    @(negedge clk); #2;
    reset = 1'b0;

    issue(16'd0, 1'b0);     idle(12);
    issue(16'd1, 1'b0);     idle(12);
    issue(16'd65535, 1'b0); idle(12);
    issue(16'd144, 1'b0);   idle(12);
    issue(16'd150, 1'b1);   idle(12);
    issue(16'd168, 1'b1);   idle(12);
    issue(16'd65535, 1'b1); idle(12);

    issue(16'd200, 1'b0);
    idle(3);
    issue(16'd4, 1'b0);
    idle(12);

    repeat (30) issue(W'($urandom), 1'($urandom));
    idle(12);

    repeat (1500) begin
      issue(W'($urandom), 1'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(12);

    issue(16'd50000, 1'b0);
    idle(4);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_root", int'(root), 0);
    check("abort_rem", int'(remainder), 0);
    q.delete();
    held_r  = 0;
    held_m  = 0;
    next_ok = 0;
    start   = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    idle(12);

    issue(16'd10000, 1'b1);
    idle(2);
    for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
